// File: rtl/barrel_rotl_seq_if.sv
// barrel_rotl_seq_if
// Handshake bundle for the sequential 8-bit left-rotate unit.
//   Request side : in_valid, in_ready, d[7:0], c[2:0]
//   Result side  : out_valid, out_ready, out[7:0]
//   Status       : busy
// Modports:
//   master - the requester/consumer (drives in_valid, d, c, out_ready)
//   slave  - the rotate unit (drives in_ready, out_valid, out, busy)
`timescale 1ns/1ps
interface barrel_rotl_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic [2:0] c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       busy;

  modport master (
    output in_valid, d, c, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, d, c, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/barrel_rotl_seq.sv
// barrel_rotl_seq
// Sequential 8-bit left-rotate: out[i] = d[(i - c) mod 8]. A single 8-bit
// register is rotated over several cycles instead of using a full mux array.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - barrel_rotl_seq_if.slave (in_valid/in_ready/d/c request,
//           out_valid/out_ready/out result, busy status)
// Configuration macro: BARREL_ROTL_FAST_EN
//   undefined - rotate one position per SHIFT cycle (c cycles)
//   defined   - rotate by the largest power of two <= remaining count per
//               cycle (popcount(c) cycles); results are identical.
`timescale 1ns/1ps
module barrel_rotl_seq (
  input logic              clk,
  input logic              rst_n,
  barrel_rotl_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;

  // Rotate an 8-bit word left by 0..7: upper byte of the doubled word.
  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] a);
    logic [15:0] w;
    w = {v, v} << a;
    return w[15:8];
  endfunction

`ifdef BARREL_ROTL_FAST_EN
  // Largest power of two not exceeding the remaining count (4, 2 or 1).
  function automatic logic [2:0] step_amt(input logic [2:0] n);
    logic [2:0] s;
    if (n[2]) begin
      s = 3'd4;
    end else if (n[1]) begin
      s = 3'd2;
    end else begin
      s = 3'd1;
    end
    return s;
  endfunction
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.d;
          cnt_d   = bus.c;
          state_d = (bus.c == 3'd0) ? ST_HOLD : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
`ifdef BARREL_ROTL_FAST_EN
        data_d = rotl8(data_q, step_amt(cnt_q));
        cnt_d  = cnt_q - step_amt(cnt_q);
        // '<=' rather than '==' so a corrupted count can never wrap.
        if (cnt_q <= step_amt(cnt_q)) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_SHIFT;
        end
`else
        data_d = rotl8(data_q, 3'd1);
        cnt_d  = cnt_q - 3'd1;
        // '<=' rather than '==' so a corrupted zero count cannot wrap.
        if (cnt_q <= 3'd1) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_SHIFT;
        end
`endif
      end
      ST_HOLD: begin
        // No bypass: consuming the result only returns to IDLE.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        data_d  = 8'h00;
        cnt_d   = 3'd0;
      end
    endcase

    // Handshake/status outputs are registered, decoded from the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d == ST_SHIFT) || (state_d == ST_HOLD);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= 8'h00;
      cnt_q       <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out       = data_q;

endmodule

// File: tb/tb_barrel_rotl_seq.sv
// tb_barrel_rotl_seq
// Directed-vector bench for barrel_rotl_seq. Inputs change away from the
// rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_barrel_rotl_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  barrel_rotl_seq_if bus ();

  barrel_rotl_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it does not match.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for the result; called at a negedge.
  // exp_lat is the number of rising edges after acceptance before out_valid.
  task automatic run_req(input string tag, input logic [7:0] dv, input logic [2:0] cv,
                         input logic [7:0] exp_out, input int exp_lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.d        = dv;
    bus.c        = cv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.d        = 8'h00;
    bus.c        = 3'd0;
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_out"}, {24'd0, bus.out}, {24'd0, exp_out});
    check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    check_val({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

`ifdef BARREL_ROTL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  initial begin
    int seen;
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.d         = 8'h00;
    bus.c         = 3'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_out", {24'd0, bus.out}, 32'h00);
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed vectors, out_ready held high: each result drains next edge
    run_req("b1_c3", 8'hB1, 3'd3, 8'h8D, FAST ? 2 : 3);
    @(negedge clk);
    check_val("b1_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("b1_drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
    run_req("a5_c0", 8'hA5, 3'd0, 8'hA5, 0);
    @(negedge clk);
    run_req("01_c7", 8'h01, 3'd7, 8'h80, FAST ? 3 : 7);
    @(negedge clk);
    run_req("e1_c5", 8'hE1, 3'd5, 8'h3C, FAST ? 2 : 5);
    @(negedge clk);
    run_req("c3_c4", 8'hC3, 3'd4, 8'h3C, FAST ? 1 : 4);
    @(negedge clk);
    check_val("c3_drain_busy", {31'd0, bus.busy}, 32'd0);

    // Backpressure: result held for 10 cycles, in_valid pulses ignored
    bus.out_ready = 1'b0;
    run_req("bp", 8'hB1, 3'd3, 8'h8D, FAST ? 2 : 3);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.d        = 8'h5A;
      bus.c        = 3'd2;
      @(negedge clk);
      check_val("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check_val("bp_out", {24'd0, bus.out}, 32'h8D);
      check_val("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_val("bp_no_accept_busy", {31'd0, bus.busy}, 32'd0);
    bus.out_ready = 1'b1;

    // Reset asserted mid-SHIFT discards the in-flight word
    bus.d        = 8'hFF;
    bus.c        = 3'd6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out", {24'd0, bus.out}, 32'h00);
    check_val("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_val("midrst_no_result", seen, 0);
    run_req("12_c1", 8'h12, 3'd1, 8'h24, 1);
    @(negedge clk);
    check_val("end_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
